// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter. The master drives the count
// controls and the slave (the counter) returns its count and flags.
interface mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] preset;
    logic             ovf_clr;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             wrapped;
    logic             ovf;

    modport master (
        output en, up, clear, load, preset, ovf_clr,
        input  out, tc, wrapped, ovf
    );

    modport slave (
        input  en, up, clear, load, preset, ovf_clr,
        output out, tc, wrapped, ovf
    );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with clear, preset load, wrap or saturate at
// the range ends, a registered wrap pulse and a sticky overflow flag.
module mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter bit          SATURATE = 1'b0
) (
    input logic          clk,
    input logic          reset,
    mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrapped_q, wrapped_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic             at_top, at_bot;

    assign at_top = (out_q == MaxVal);
    assign at_bot = (out_q == '0);

    always_comb begin
        out_d     = out_q;
        wrapped_d = 1'b0;
        ovf_set   = 1'b0;
        if (bus.clear) begin
            out_d = '0;
        end else if (bus.load) begin
            // Out-of-range presets clamp to the top of the range and flag it.
            if (bus.preset > MaxVal) begin
                out_d   = MaxVal;
                ovf_set = 1'b1;
            end else begin
                out_d = bus.preset;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_top) begin
                    ovf_set = 1'b1;
                    if (!SATURATE) begin
                        out_d     = '0;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    ovf_set = 1'b1;
                    if (!SATURATE) begin
                        out_d     = MaxVal;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
        end
        // A set event on the same edge wins over the clear request.
        ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            wrapped_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            wrapped_q <= wrapped_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        bus.out     = out_q;
        bus.wrapped = wrapped_q;
        bus.ovf     = ovf_q;
        bus.tc      = bus.en & ((bus.up & at_top) | (~bus.up & at_bot));
    end
endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations driven in lockstep, checked
// every cycle against an arithmetic model plus hand-computed scenarios.
module tb_mod_counter;
    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, clear, load, ovf_clr;
    logic [3:0] preset;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    int m_out[3] = '{0, 0, 0};
    bit m_wr[3]  = '{0, 0, 0};
    bit m_ovf[3] = '{0, 0, 0};

    mod_counter_if #(.WIDTH(4)) bus0 ();
    mod_counter_if #(.WIDTH(4)) bus1 ();
    mod_counter_if #(.WIDTH(4)) bus2 ();

    assign bus0.en = en;  assign bus0.up = up;  assign bus0.clear = clear;
    assign bus0.load = load;  assign bus0.preset = preset;  assign bus0.ovf_clr = ovf_clr;
    assign bus1.en = en;  assign bus1.up = up;  assign bus1.clear = clear;
    assign bus1.load = load;  assign bus1.preset = preset;  assign bus1.ovf_clr = ovf_clr;
    assign bus2.en = en;  assign bus2.up = up;  assign bus2.clear = clear;
    assign bus2.load = load;  assign bus2.preset = preset;  assign bus2.ovf_clr = ovf_clr;

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    always #5 clk = ~clk;

    function automatic int mod_of(int k);
        return (k == 2) ? 16 : 10;
    endfunction

    function automatic bit sat_of(int k);
        return (k == 1);
    endfunction

    // s: 0 = out, 1 = tc, 2 = wrapped, 3 = ovf
    function automatic int rd(int k, int s);
        logic [3:0] o;
        logic       t, w, v;
        case (k)
            0:       begin o = bus0.out; t = bus0.tc; w = bus0.wrapped; v = bus0.ovf; end
            1:       begin o = bus1.out; t = bus1.tc; w = bus1.wrapped; v = bus1.ovf; end
            default: begin o = bus2.out; t = bus2.tc; w = bus2.wrapped; v = bus2.ovf; end
        endcase
        case (s)
            0:       return int'(o);
            1:       return int'(t);
            2:       return int'(w);
            default: return int'(v);
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value-level rules with plain integer arithmetic.
    always @(posedge clk or negedge reset) begin
        int  m, nxt;
        bit  w, setf;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                m_out[k] <= 0;
                m_wr[k]  <= 1'b0;
                m_ovf[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m    = mod_of(k);
                nxt  = m_out[k];
                w    = 1'b0;
                setf = 1'b0;
                if (clear) begin
                    nxt = 0;
                end else if (load) begin
                    if (int'(preset) >= m) begin
                        nxt  = m - 1;
                        setf = 1'b1;
                    end else begin
                        nxt = int'(preset);
                    end
                end else if (en) begin
                    nxt = m_out[k] + (up ? 1 : -1);
                    if (nxt < 0 || nxt >= m) begin
                        setf = 1'b1;
                        if (sat_of(k)) begin
                            nxt = m_out[k];
                        end else begin
                            nxt = (nxt + m) % m;
                            w   = 1'b1;
                        end
                    end
                end
                m_out[k] <= nxt;
                m_wr[k]  <= w;
                m_ovf[k] <= setf | (m_ovf[k] & !ovf_clr);
            end
        end
    end

    always @(negedge clk) begin
        int exp_tc;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_tc = (en && ((up && m_out[k] == mod_of(k) - 1) || (!up && m_out[k] == 0)))
                         ? 1 : 0;
                chk($sformatf("dut%0d out", k), rd(k, 0), m_out[k]);
                chk($sformatf("dut%0d tc", k), rd(k, 1), exp_tc);
                chk($sformatf("dut%0d wrapped", k), rd(k, 2), int'(m_wr[k]));
                chk($sformatf("dut%0d ovf", k), rd(k, 3), int'(m_ovf[k]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit c, bit l, int p, bit e, bit u, bit oc);
        clear   = c;
        load    = l;
        preset  = 4'(p);
        en      = e;
        up      = u;
        ovf_clr = oc;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("reset out", rd(k, 0), 0);
            chk("reset ovf", rd(k, 3), 0);
            chk("reset wrapped", rd(k, 2), 0);
        end
        reset = 1'b1;

        // Up-wrap on the wrapping counter, saturating neighbour alongside.
        drive(0, 1, 8, 0, 0, 0);
        cyc();
        chk("upwrap load", rd(0, 0), 8);
        drive(0, 0, 0, 1, 1, 0);
        #1 chk("upwrap tc at 8", rd(0, 1), 0);
        cyc();
        chk("upwrap out 9", rd(0, 0), 9);
        #1 chk("upwrap tc at 9", rd(0, 1), 1);
        cyc();
        chk("upwrap out 0", rd(0, 0), 0);
        chk("upwrap wrapped", rd(0, 2), 1);
        chk("upwrap ovf", rd(0, 3), 1);
        chk("upsat hold 9", rd(1, 0), 9);
        chk("upsat wrapped", rd(1, 2), 0);
        chk("m16 out 10", rd(2, 0), 10);
        cyc();
        chk("upwrap out 1", rd(0, 0), 1);
        chk("upwrap pulse end", rd(0, 2), 0);

        // Down-saturate.
        drive(0, 1, 1, 0, 0, 1);
        cyc();
        chk("dnsat load 1", rd(1, 0), 1);
        chk("dnsat ovf cleared", rd(1, 3), 0);
        drive(0, 0, 0, 1, 0, 0);
        cyc();
        chk("dnsat out 0 a", rd(1, 0), 0);
        chk("dnsat ovf still 0", rd(1, 3), 0);
        cyc();
        chk("dnsat out 0 b", rd(1, 0), 0);
        chk("dnsat ovf", rd(1, 3), 1);
        chk("dnsat wrapped", rd(1, 2), 0);
        cyc();
        chk("dnsat out 0 c", rd(1, 0), 0);
        chk("dnwrap out 8", rd(0, 0), 8);

        // Illegal load clamps, then sticky flag cleared.
        drive(0, 1, 12, 0, 0, 1);
        cyc();
        chk("illegal clamp", rd(0, 0), 9);
        chk("illegal ovf", rd(0, 3), 1);
        chk("m16 legal 12", rd(2, 0), 12);
        drive(0, 0, 0, 0, 0, 1);
        cyc();
        chk("ovf_clr", rd(0, 3), 0);

        // Priority clear > load > count.
        drive(1, 1, 5, 1, 1, 0);
        cyc();
        chk("prio clear", rd(0, 0), 0);
        drive(0, 1, 5, 1, 1, 0);
        cyc();
        chk("prio load", rd(0, 0), 5);

        // Reset mid-count with ovf set.
        drive(0, 1, 15, 0, 0, 0);
        cyc();
        chk("pre-reset ovf", rd(0, 3), 1);
        drive(0, 1, 5, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 1, 1, 0);
        cyc();
        cyc();
        chk("count to 7", rd(0, 0), 7);
        reset = 1'b0;
        #1;
        chk("async reset out", rd(0, 0), 0);
        chk("async reset ovf", rd(0, 3), 0);
        cyc();
        chk("held in reset", rd(0, 0), 0);
        reset = 1'b1;
        cyc();
        chk("resume count", rd(0, 0), 1);

        // Natural binary wrap on the full-range counter.
        drive(0, 1, 15, 0, 0, 1);
        cyc();
        chk("m16 load 15", rd(2, 0), 15);
        drive(0, 0, 0, 1, 1, 0);
        cyc();
        chk("m16 wrap 0", rd(2, 0), 0);
        chk("m16 wrapped", rd(2, 2), 1);
        drive(0, 0, 0, 1, 0, 0);
        cyc();
        chk("m16 down 15", rd(2, 0), 15);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(15) == 0), ($urandom_range(7) == 0), $urandom_range(15),
                  ($urandom_range(3) != 0), $urandom_range(1) == 1, ($urandom_range(7) == 0));
            reset = ($urandom_range(63) != 0);
            cyc();
        end
        reset = 1'b1;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 256: count range is 0..MODULUS-1; legal values are 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port clear  input  1  synchronous clear to 0.
REQ-009 SHALL have port load  input  1  synchronous load of preset.
REQ-010 SHALL have port preset  input  WIDTH  load value.
REQ-011 SHALL have port ovf_clr  input  1  clears the sticky ovf flag.
REQ-012 SHALL have port out  output  WIDTH  registered count value.
REQ-013 SHALL have port tc  output  1  combinational terminal-count indication, for cascading.
REQ-014 SHALL have port wrapped  output  1  registered one-cycle pulse per wrap event.
REQ-015 SHALL have port ovf  output  1  registered sticky overflow/underflow/illegal-load flag.

Function
REQ-016 SHALL apply per-edge priority: clear > load > (en count) > hold.
REQ-017 SHALL, on clear=1, set out=0 next edge, regardless of load/en.
REQ-018 SHALL, on load=1 with preset <= MODULUS-1, set out=preset next edge.
REQ-019 SHALL, on load=1 with preset >= MODULUS, set out=MODULUS-1 and set ovf.
REQ-020 SHALL, on en=1 with up=1 and out<MODULUS-1, set out=out+1; with up=0 and out>0, set out=out-1.
REQ-021 SHALL, on en=1 with up=1 and out=MODULUS-1, set out=0 when SATURATE=0 and hold out when SATURATE=1.
REQ-022 SHALL, on en=1 with up=0 and out=0, set out=MODULUS-1 when SATURATE=0 and hold out when SATURATE=1.
REQ-023 SHALL set ovf at every boundary event of REQ-021/REQ-022, in both SATURATE modes.
REQ-024 SHALL assert wrapped for exactly the cycle after a wrap transition, with SATURATE=0 only; wrapped SHALL be 0 when SATURATE=1.
REQ-025 SHALL drive tc = en AND ((up AND out=MODULUS-1) OR (NOT up AND out=0)), with no register on tc.
REQ-026 SHALL clear ovf on ovf_clr=1, except that a same-edge set event wins and ovf stays 1.
REQ-027 SHALL compute all arithmetic at WIDTH bits with no intermediate overflow; MODULUS=2**WIDTH SHALL behave as natural binary wrap.
REQ-028 SHALL never present out >= MODULUS after any edge.
REQ-029 SHALL leave ovf unaffected by clear.

Reset
REQ-030 SHALL, while reset=0, force out=0, wrapped=0 and ovf=0 immediately, without waiting for a clk edge.
REQ-031 SHALL ignore all inputs while reset=0 and resume counting at the first rising clk edge after reset returns to 1.
REQ-032 SHALL abandon any in-progress load or count on reset assertion mid-operation; no partial update is retained.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-033 SHALL cover up-wrap with SATURATE=0: load 8, then en=1 up=1 for 3 edges -> out 9,0,1; tc=1 while out=9; wrapped=1 the single cycle out=0; ovf=1.
REQ-034 SHALL cover down-saturate with SATURATE=1: out=1, en=1 up=0 for 3 edges -> out 0,0,0; wrapped stays 0; ovf=1 after the second edge.
REQ-035 SHALL cover illegal load: preset=12, load=1 -> out=9, ovf=1; then ovf_clr=1 -> ovf=0.
REQ-036 SHALL cover priority: clear=1, load=1 (preset=5) and en=1 on one edge -> out=0; then load=1 with en=1 -> out=5.
REQ-037 SHALL cover reset mid-count: count to 7, then reset=0 between edges -> out=0 and ovf=0 at once, before any edge; after release, en=1 up=1 -> out=1 at first edge.
REQ-038 SHALL cover natural wrap with MODULUS=16: out=15, en=1 up=1 -> out=0 and wrapped=1; out=0, up=0 -> out=15.
